// File: rtl/patch_netlist_eval_pkg.sv
// patch_netlist_eval_pkg: shared opcodes, FSM states, error codes and fixed wire ids for the patch netlist evaluator.
package patch_eval_pkg;
    typedef enum logic [2:0] {
        OP_BUF  = 3'd0,
        OP_NOT  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDEF_SRC = 2'd1;
    localparam logic [1:0] ERR_ILL_DST   = 2'd2;
    localparam logic [1:0] ERR_ILL_OP    = 2'd3;

    localparam int CONST0_ID = 0;
    localparam int CONST1_ID = 1;
    localparam int PI_BASE   = 2;
endpackage

// File: rtl/patch_netlist_eval_if.sv
// patch_netlist_eval_if: run control, gate record stream and result signals of the evaluator.
interface patch_netlist_eval_if #(
    parameter int ID_W   = 6,
    parameter int NUM_PI = 3
);
    logic              start;
    logic [NUM_PI-1:0] pi_vec;
    logic [ID_W-1:0]   out_id;
    logic              gate_valid;
    logic              gate_ready;
    logic [2:0]        gate_op;
    logic [ID_W-1:0]   gate_src0;
    logic [ID_W-1:0]   gate_src1;
    logic [ID_W-1:0]   gate_dst;
    logic              gate_last;
    logic              result_valid;
    logic              result;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output start, pi_vec, out_id, gate_valid, gate_op, gate_src0, gate_src1, gate_dst, gate_last,
        input  gate_ready, result_valid, result, err, err_code
    );

    modport slave (
        input  start, pi_vec, out_id, gate_valid, gate_op, gate_src0, gate_src1, gate_dst, gate_last,
        output gate_ready, result_valid, result, err, err_code
    );
endinterface

// File: rtl/patch_netlist_eval_alu.sv
// patch_gate_alu: single-gate evaluator; PATCH_EVAL_EXT_OPS_EN enables OR/NAND/NOR/XOR/XNOR,
// otherwise opcodes 3..7 are flagged illegal.
module patch_gate_alu
    import patch_eval_pkg::*;
(
    input  op_e  op_i,
    input  logic a_i,
    input  logic b_i,
    output logic y_o,
    output logic illegal_op_o
);
    always_comb begin
        y_o = 1'b0;
        illegal_op_o = 1'b0;
        case (op_i)
            OP_BUF:  y_o = a_i;
            OP_NOT:  y_o = !a_i;
            OP_AND:  y_o = a_i & b_i;
`ifdef PATCH_EVAL_EXT_OPS_EN
            OP_OR:   y_o = a_i | b_i;
            OP_NAND: y_o = !(a_i & b_i);
            OP_NOR:  y_o = !(a_i | b_i);
            OP_XOR:  y_o = a_i ^ b_i;
            OP_XNOR: y_o = !(a_i ^ b_i);
`endif
            default: illegal_op_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/patch_netlist_eval.sv
// patch_netlist_eval: streams gate records into a per-wire value/defined store and reports one wire.
// Optional extended opcodes are enabled with PATCH_EVAL_EXT_OPS_EN (see patch_gate_alu).
module patch_netlist_eval
    import patch_eval_pkg::*;
#(
    parameter int NUM_WIRES = 64,
    parameter int ID_W      = 6,
    parameter int NUM_PI    = 3
) (
    input logic clk,
    input logic rst,
    patch_netlist_eval_if.slave bus
);
    state_e              state_q;
    logic [NUM_WIRES-1:0] val_q;
    logic [NUM_WIRES-1:0] def_q;
    logic [NUM_PI-1:0]   pi_q;
    logic [ID_W-1:0]     out_id_q;
    logic [1:0]          err_code_q;
    op_e                 op;
    logic                alu_y;
    logic                ill_op;
    logic                two_in;
    logic                s0_ok;
    logic                s1_ok;
    logic                dst_ok;
    logic                out_def;
    logic [1:0]          rec_err;

    function automatic logic in_range(input logic [ID_W-1:0] id);
        return int'(id) < NUM_WIRES;
    endfunction

    assign op      = op_e'(bus.gate_op);
    assign two_in  = (op != OP_BUF) && (op != OP_NOT);
    assign s0_ok   = in_range(bus.gate_src0) && def_q[bus.gate_src0];
    assign s1_ok   = in_range(bus.gate_src1) && def_q[bus.gate_src1];
    assign dst_ok  = (int'(bus.gate_dst) > NUM_PI + 1) && in_range(bus.gate_dst) && !def_q[bus.gate_dst];
    assign out_def = in_range(out_id_q) && def_q[out_id_q];
    // Opcode errors dominate source errors, which dominate destination errors.
    assign rec_err = ill_op ? ERR_ILL_OP :
                     (!s0_ok || (two_in && !s1_ok)) ? ERR_UNDEF_SRC :
                     !dst_ok ? ERR_ILL_DST : ERR_NONE;

    patch_gate_alu u_alu (
        .op_i         (op),
        .a_i          (val_q[bus.gate_src0]),
        .b_i          (val_q[bus.gate_src1]),
        .y_o          (alu_y),
        .illegal_op_o (ill_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            val_q      <= '0;
            def_q      <= '0;
            pi_q       <= '0;
            out_id_q   <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            case (state_q)
                S_LOAD: begin
                    def_q                   <= '0;
                    def_q[CONST0_ID]        <= 1'b1;
                    def_q[CONST1_ID]        <= 1'b1;
                    def_q[PI_BASE +: NUM_PI] <= '1;
                    val_q[CONST0_ID]        <= 1'b0;
                    val_q[CONST1_ID]        <= 1'b1;
                    val_q[PI_BASE +: NUM_PI] <= pi_q;
                    state_q                 <= S_EVAL;
                end
                S_EVAL: begin
                    if (bus.gate_valid) begin
                        if (rec_err != ERR_NONE) begin
                            state_q    <= S_ERR;
                            err_code_q <= rec_err;
                        end else begin
                            val_q[bus.gate_dst] <= alu_y;
                            def_q[bus.gate_dst] <= 1'b1;
                            if (bus.gate_last) state_q <= S_DONE;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_q    <= S_LOAD;
                        pi_q       <= bus.pi_vec;
                        out_id_q   <= bus.out_id;
                        err_code_q <= ERR_NONE;
                    end else if (state_q == S_DONE && !out_def) begin
                        state_q    <= S_ERR;
                        err_code_q <= ERR_UNDEF_SRC;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gate_ready   = state_q == S_EVAL;
    assign bus.result_valid = (state_q == S_DONE) && out_def;
    assign bus.result       = bus.result_valid && val_q[out_id_q];
    assign bus.err          = state_q == S_ERR;
    assign bus.err_code     = err_code_q;
endmodule
